// File: rtl/wb_port_arbiter_pkg.sv
// Shared definitions for the register-file write-port arbiter.
//   WB_DATA_W / WB_ADDR_W : default register data / index widths
//   wb_entry_t            : one buffered aux result {rd, data, kill}
//   arb_state_t           : starvation-guard FSM states
//   slot_busy()           : true when the pipeline really writes a register
package wb_port_arbiter_pkg;

    localparam int WB_DATA_W = 32;
    localparam int WB_ADDR_W = 5;

    typedef struct packed {
        logic [WB_ADDR_W-1:0] rd;
        logic [WB_DATA_W-1:0] data;
        logic                 kill;
    } wb_entry_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_STEAL = 2'd2
    } arb_state_t;

    // A write to x0 never occupies the port.
    function automatic logic slot_busy(input logic we, input logic [WB_ADDR_W-1:0] rd);
        return we && (rd != '0);
    endfunction

endpackage

// File: rtl/wb_aux_fifo.sv
// DEPTH-entry in-order buffer for auxiliary-unit results, with kill-by-rd.
//   clk, rst_n       : clock, asynchronous active-low reset (pointers only)
//   push_i           : write push_rd_i/push_data_i at the tail (caller ensures !full_o)
//   pop_i            : drop the head entry (caller ensures !empty_o)
//   kill_en_i        : pipeline writes kill_rd_i this cycle; matching entries,
//                      including one pushed this cycle, get their kill bit set
//   head_o           : current head entry
//   full_o, empty_o  : occupancy flags, valid before this cycle's push/pop
module wb_aux_fifo
    import wb_port_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 push_i,
    input  logic [WB_ADDR_W-1:0] push_rd_i,
    input  logic [WB_DATA_W-1:0] push_data_i,
    input  logic                 pop_i,
    input  logic                 kill_en_i,
    input  logic [WB_ADDR_W-1:0] kill_rd_i,
    output wb_entry_t            head_o,
    output logic                 full_o,
    output logic                 empty_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_idx, rd_idx;
    wb_entry_t     mem_q [DEPTH];

    assign wr_idx  = wr_ptr_q[AW-1:0];
    assign rd_idx  = rd_ptr_q[AW-1:0];
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_idx == rd_idx) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign head_o  = mem_q[rd_idx];

    assign wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push_i};
    assign rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop_i};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: an entry is only observed after it was pushed.
    // The slot being pushed is never occupied, so push and kill never collide.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (push_i && (wr_idx == AW'(i))) begin
                mem_q[i] <= '{rd:   push_rd_i,
                              data: push_data_i,
                              kill: kill_en_i && (push_rd_i == kill_rd_i)};
            end else if (kill_en_i && (mem_q[i].rd == kill_rd_i)) begin
                mem_q[i].kill <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between the pipeline write-back stage
// (absolute priority) and a buffered multi-cycle auxiliary unit.
//   clk, rst_n                    : clock, asynchronous active-low reset
//   pipe_reg_write/pipe_rd/_data  : pipeline write request (never back-pressured)
//   aux_valid/aux_ready/aux_rd/_data : aux result handshake into the buffer
//   rf_we/rf_waddr/rf_wdata       : register-file write port (combinational)
//   fwd_valid/fwd_rd/fwd_data     : MEM/WB forwarding copy of the write port
//   pipe_stall                    : one-cycle stall that frees a slot for a starved buffer
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int DATA_W       = WB_DATA_W,
    parameter int ADDR_W       = WB_ADDR_W,
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pipe_reg_write,
    input  logic [ADDR_W-1:0] pipe_rd,
    input  logic [DATA_W-1:0] pipe_data,
    input  logic              aux_valid,
    output logic              aux_ready,
    input  logic [ADDR_W-1:0] aux_rd,
    input  logic [DATA_W-1:0] aux_data,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              pipe_stall,
    output logic [ADDR_W-1:0] fwd_rd,
    output logic [DATA_W-1:0] fwd_data,
    output logic              fwd_valid
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);

    logic       busy, push, pop, full, empty;
    wb_entry_t  head;
    arb_state_t state_q;
    logic [CW-1:0] cnt_q;
    logic       stall_q;

    // Gated by rst_n so the write port is silent while reset is held.
    assign busy      = rst_n & slot_busy(pipe_reg_write, pipe_rd);
    assign aux_ready = !full;
    assign push      = aux_valid & !full;
    assign pop       = !busy & !empty;

    wb_aux_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (push),
        .push_rd_i   (aux_rd),
        .push_data_i (aux_data),
        .pop_i       (pop),
        .kill_en_i   (busy),
        .kill_rd_i   (pipe_rd),
        .head_o      (head),
        .full_o      (full),
        .empty_o     (empty)
    );

    // Killed or x0 entries still pop and use up the free slot, but do not write.
    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = '0;
        rf_wdata = '0;
        if (busy) begin
            rf_we    = 1'b1;
            rf_waddr = pipe_rd;
            rf_wdata = pipe_data;
        end else if (pop) begin
            rf_we    = !head.kill && (head.rd != '0);
            rf_waddr = head.rd;
            rf_wdata = head.data;
        end
    end

    assign fwd_valid  = rf_we;
    assign fwd_rd     = rf_waddr;
    assign fwd_data   = rf_wdata;
    assign pipe_stall = stall_q;

    // Starvation guard: count busy cycles while the buffer stays full, then
    // request one stall. The counter survives the STEAL cycle even if the
    // pipeline still wins it, and is only cleared back in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            stall_q <= 1'b0;
        end else begin
            stall_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    cnt_q <= '0;
                    if (full) state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (!full) begin
                        state_q <= ST_IDLE;
                    end else if (busy && (cnt_q == CW'(STARVE_LIMIT - 1))) begin
                        state_q <= ST_STEAL;
                        stall_q <= 1'b1;
                    end else if (busy) begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                ST_STEAL: state_q <= ST_IDLE;
                default:  state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Randomized self-checking bench for wb_port_arbiter against a queue-based
// behavioural model of the write-port sharing rules.
module tb_wb_port_arbiter;

    localparam int DEPTH = 2;
    localparam int LIM   = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pipe_reg_write;
    logic [4:0]  pipe_rd;
    logic [31:0] pipe_data;
    logic        aux_valid;
    logic        aux_ready;
    logic [4:0]  aux_rd;
    logic [31:0] aux_data;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        pipe_stall;
    logic [4:0]  fwd_rd;
    logic [31:0] fwd_data;
    logic        fwd_valid;

    always #5 clk = ~clk;

    wb_port_arbiter #(
        .DATA_W (32), .ADDR_W (5), .DEPTH (DEPTH), .STARVE_LIMIT (LIM)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pipe_reg_write (pipe_reg_write),
        .pipe_rd        (pipe_rd),
        .pipe_data      (pipe_data),
        .aux_valid      (aux_valid),
        .aux_ready      (aux_ready),
        .aux_rd         (aux_rd),
        .aux_data       (aux_data),
        .rf_we          (rf_we),
        .rf_waddr       (rf_waddr),
        .rf_wdata       (rf_wdata),
        .pipe_stall     (pipe_stall),
        .fwd_rd         (fwd_rd),
        .fwd_data       (fwd_data),
        .fwd_valid      (fwd_valid)
    );

    // Behavioural model state
    typedef struct {
        int          rd;
        logic [31:0] data;
        bit          kill;
    } m_ent_t;

    m_ent_t mq[$];
    bit     m_stall;      // model says pipe_stall is high this cycle
    bit     after_stall;  // previous cycle was a stall cycle: pipeline must idle
    bit     watching;     // buffer was seen full and busy cycles are being counted
    int     starve;       // busy cycles counted while watching
    int     dut_stalls;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        m_stall     = 1'b0;
        after_stall = 1'b0;
        watching    = 1'b0;
        starve      = 0;
    endtask

    // One clock cycle: drive, compare combinational outputs, advance model.
    task automatic step(input bit we, input int rd, input logic [31:0] d,
                        input bit av, input int ard, input logic [31:0] ad);
        bit          busy, full, e_we, nxt_stall;
        int          e_addr;
        logic [31:0] e_data;
        if (after_stall) we = 1'b0;
        pipe_reg_write = we;
        pipe_rd        = rd[4:0];
        pipe_data      = d;
        aux_valid      = av;
        aux_rd         = ard[4:0];
        aux_data       = ad;
        @(negedge clk);
        busy   = we && (rd != 0);
        full   = (mq.size() == DEPTH);
        e_we   = 1'b0;
        e_addr = 0;
        e_data = '0;
        if (busy) begin
            e_we = 1'b1; e_addr = rd; e_data = d;
        end else if (mq.size() > 0) begin
            e_we   = !mq[0].kill && (mq[0].rd != 0);
            e_addr = mq[0].rd;
            e_data = mq[0].data;
        end
        check("rf_we", rf_we, e_we);
        check("fwd_valid", fwd_valid, e_we);
        if (e_we) begin
            check("rf_waddr", rf_waddr, e_addr);
            check("rf_wdata", rf_wdata, e_data);
            check("fwd_rd", fwd_rd, e_addr);
            check("fwd_data", fwd_data, e_data);
        end
        check("aux_ready", aux_ready, !full);
        check("pipe_stall", pipe_stall, m_stall);
        if (pipe_stall) dut_stalls++;

        // Starvation rule: once full is noticed, busy cycles that follow while
        // still full are counted; the LIM-th one requests a stall next cycle.
        nxt_stall = 1'b0;
        if (m_stall) begin
            watching = 1'b0;
        end else if (!watching) begin
            watching = full;
            starve   = 0;
        end else if (!full) begin
            watching = 1'b0;
        end else if (busy) begin
            if (starve == LIM - 1) begin
                nxt_stall = 1'b1;
                watching  = 1'b0;
            end else begin
                starve++;
            end
        end

        // Younger pipeline write kills older buffered results to the same rd.
        if (busy)
            foreach (mq[i]) if (mq[i].rd == rd) mq[i].kill = 1'b1;
        if (!busy && mq.size() > 0) void'(mq.pop_front());
        if (av && !full) mq.push_back('{ard, ad, busy && (ard == rd)});

        after_stall = m_stall;
        m_stall     = nxt_stall;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0, '0, 1'b0, 0, '0);
    endtask

    // Assert reset in the middle of a cycle and check the async response.
    task automatic mid_reset();
        pipe_reg_write = 1'b0;
        aux_valid      = 1'b0;
        #3;
        check("pre_rst_we", rf_we, (mq.size() > 0 && !mq[0].kill && mq[0].rd != 0));
        rst_n = 1'b0;
        #1;
        check("rst_rf_we", rf_we, 1'b0);
        check("rst_fwd_valid", fwd_valid, 1'b0);
        check("rst_stall", pipe_stall, 1'b0);
        check("rst_aux_ready", aux_ready, 1'b1);
        check("rst_waddr", rf_waddr, '0);
        check("rst_wdata", rf_wdata, '0);
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    int base;
    int p_busy;

    initial begin
        rst_n = 1'b0;
        pipe_reg_write = 1'b0; pipe_rd = '0; pipe_data = '0;
        aux_valid = 1'b0; aux_rd = '0; aux_data = '0;
        model_clear();
        dut_stalls = 0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_rf_we", rf_we, 1'b0);
        check("reset_stall", pipe_stall, 1'b0);
        check("reset_aux_ready", aux_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Aux result into an empty buffer is written the next cycle.
        step(1'b0, 0, '0, 1'b1, 3, 32'hDEADBEEF);
        idle(2);
        // Pipeline write and aux push in the same cycle.
        step(1'b1, 5, 32'h11, 1'b1, 6, 32'h22);
        idle(2);
        // WAW kill: buffered r7 is superseded by the pipeline.
        step(1'b0, 0, '0, 1'b1, 7, 32'hAA);
        step(1'b1, 7, 32'hBB, 1'b0, 0, '0);
        idle(2);
        // Same-cycle push and kill.
        step(1'b1, 9, 32'h99, 1'b1, 9, 32'h98);
        idle(2);
        // Starvation: fill the buffer and keep the pipeline busy.
        base = dut_stalls;
        step(1'b1, 1, 32'h101, 1'b1, 12, 32'hC12);
        step(1'b1, 2, 32'h102, 1'b1, 13, 32'hC13);
        for (int i = 0; i < 10; i++) step(1'b1, 20 + i, 32'h200 + i, 1'b0, 0, '0);
        check("t5_one_stall", dut_stalls - base, 1);
        idle(3);
        // x0 from both sources never writes; the aux x0 entry still pops.
        step(1'b0, 0, '0, 1'b1, 0, 32'h55);
        step(1'b1, 0, 32'h66, 1'b0, 0, '0);
        idle(2);
        // Reset in the middle of a drain discards the buffer.
        step(1'b1, 1, 32'h1, 1'b1, 14, 32'hE14);
        step(1'b1, 2, 32'h2, 1'b1, 15, 32'hE15);
        mid_reset();
        idle(2);

        // Randomized phases with varying pipeline pressure; small rd range
        // makes WAW collisions and x0 requests frequent.
        for (int ph = 0; ph < 8; ph++) begin
            p_busy = (ph % 4 == 0) ? 30 : (ph % 4 == 1) ? 70 : 95;
            for (int c = 0; c < 150; c++) begin
                step(($urandom_range(99) < p_busy), $urandom_range(7), $urandom,
                     ($urandom_range(99) < 60), $urandom_range(7), $urandom);
            end
            if (ph == 5) begin
                step(1'b1, 3, 32'h3, 1'b1, 4, 32'h4);
                mid_reset();
            end
        end
        idle(4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
